// File: rtl/cpu_prog_loader_if.sv
// Command, payload stream and RAM write port of the program loader.
// The master side is the host/RAM; the loader is the slave.
interface cpu_prog_loader_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, s_valid, s_data,
        input  cmd_ready, s_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, s_valid, s_data,
        output cmd_ready, s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cpu_prog_loader.sv
// Boot loader: streams a payload into RAM, writes the 6502 reset vector,
// holds the CPU in reset for a while, then releases it.
module cpu_prog_loader #(
    parameter logic [15:0] VECTOR_ADDR = 16'hFFFC,
    parameter int unsigned RESET_HOLD  = 5
) (
    input  logic              clk,
    input  logic              rst,
    cpu_prog_loader_if.slave  bus,
    input  logic              abort,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {
        IDLE, LOAD, VEC_LO, VEC_HI, HOLD, RUN
    } state_t;

    localparam logic [15:0] HOLD_INIT = 16'(RESET_HOLD - 1);

    state_t      state, state_d;
    logic [15:0] ptr, ptr_d;
    logic [15:0] cnt, cnt_d;
    logic [15:0] vec, vec_d;
    logic [15:0] hold, hold_d;
    logic        we_d;
    logic [15:0] addr_d;
    logic [7:0]  wdata_d;
    logic        rstn_d;
    logic        done_d;
    logic        cmd_fire;
    logic        beat;

    assign bus.cmd_ready = (state == IDLE) || (state == RUN);
    assign bus.s_ready   = (state == LOAD);
    assign busy          = state inside {LOAD, VEC_LO, VEC_HI, HOLD};
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    // abort outranks a beat presented in the same cycle
    assign beat          = bus.s_valid && bus.s_ready && !abort;

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        vec_d   = vec;
        hold_d  = hold;
        we_d    = 1'b0;
        addr_d  = bus.mem_addr;
        wdata_d = bus.mem_wdata;
        rstn_d  = cpu_rst_n;
        done_d  = 1'b0;
        unique case (state)
            IDLE, RUN: begin
                if (cmd_fire) begin
                    ptr_d   = bus.cmd_addr;
                    vec_d   = bus.cmd_addr;
                    cnt_d   = bus.cmd_len;
                    rstn_d  = 1'b0;
                    state_d = (bus.cmd_len == 16'd0) ? VEC_LO : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (beat) begin
                    we_d    = 1'b1;
                    addr_d  = ptr;
                    wdata_d = bus.s_data;
                    ptr_d   = ptr + 16'd1;
                    cnt_d   = cnt - 16'd1;
                    if (cnt == 16'd1) state_d = VEC_LO;
                end
            end
            VEC_LO: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = VECTOR_ADDR;
                    wdata_d = vec[7:0];
                    state_d = VEC_HI;
                end
            end
            VEC_HI: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = VECTOR_ADDR + 16'd1;
                    wdata_d = vec[15:8];
                    hold_d  = HOLD_INIT;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hold == 16'd0) begin
                    rstn_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    hold_d = hold - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            vec           <= '0;
            hold          <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_rst_n     <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_d;
            ptr           <= ptr_d;
            cnt           <= cnt_d;
            vec           <= vec_d;
            hold          <= hold_d;
            bus.mem_we    <= we_d;
            bus.mem_addr  <= addr_d;
            bus.mem_wdata <= wdata_d;
            cpu_rst_n     <= rstn_d;
            done          <= done_d;
        end
    end
endmodule

// File: tb/tb_cpu_prog_loader.sv
// Scoreboard bench for cpu_prog_loader: expected RAM writes are queued
// as stimulus is accepted and popped as the RAM port shows them.
module tb_cpu_prog_loader;
    logic clk = 1'b0;
    logic rst;
    logic abort;
    logic cpu_rst_n;
    logic busy;
    logic done;

    cpu_prog_loader_if bus();

    cpu_prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .abort     (abort),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [23:0] sb[$];
    logic [7:0]  pay[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.mem_we) begin
            if (sb.size() == 0)
                chk("stray_we", {bus.mem_addr, bus.mem_wdata}, 32'hDEAD);
            else
                chk("wr", {8'h0, bus.mem_addr, bus.mem_wdata},
                    {8'h0, sb.pop_front()});
        end
    end

    task automatic rst_vals(input string tag);
        chk(tag, {bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst_n,
                  busy, done, bus.s_ready, ~bus.cmd_ready}, 32'h0);
    endtask

    task automatic cmd(input logic [15:0] a, input logic [15:0] l,
                       output int h);
        int t = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        while (!bus.cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready", bus.cmd_ready, 1);
        h = cyc + 1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input bit gap);
        logic [15:0] p = a;
        int i = 0;
        int t = 0;
        while (i < pay.size() && t < 200) begin
            @(negedge clk);
            t++;
            bus.s_valid = !(gap && t[0]);
            bus.s_data  = pay[i];
            if (bus.s_valid && bus.s_ready) begin
                sb.push_back({p, pay[i]});
                p++;
                i++;
            end
        end
        chk("send_cnt", i, pay.size());
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic vec(input logic [15:0] a);
        sb.push_back({16'hFFFC, a[7:0]});
        sb.push_back({16'hFFFD, a[15:8]});
    endtask

    task automatic wait_done(input int h, input int lat);
        int t = 0;
        @(negedge clk);
        chk("rst_n_low", cpu_rst_n, 0);
        chk("busy", busy, 1);
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done, 1);
        if (lat >= 0) chk("done_lat", cyc - h, lat);
        chk("rst_n_run", cpu_rst_n, 1);
        chk("busy_run", busy, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        int h;
        bit seen;
        rst = 1'b1;
        abort = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_len = '0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        #1 rst_vals("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // basic load
        cmd(16'hC000, 16'd3, h);
        pay = {8'hA9, 8'h42, 8'hEA};
        send(16'hC000, 1'b0);
        vec(16'hC000);
        wait_done(h, 10);

        // throttled stream
        cmd(16'h4000, 16'd4, h);
        pay = {8'h01, 8'h02, 8'h03, 8'h04};
        send(16'h4000, 1'b1);
        vec(16'h4000);
        wait_done(h, -1);

        // address wrap
        cmd(16'hFFFE, 16'd3, h);
        pay = {8'h11, 8'h22, 8'h33};
        send(16'hFFFE, 1'b0);
        vec(16'hFFFE);
        wait_done(h, 10);

        // zero-length
        cmd(16'h8000, 16'd0, h);
        vec(16'h8000);
        wait_done(h, 7);

        // abort with the second beat
        cmd(16'h1000, 16'd4, h);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data = 8'h5A;
        sb.push_back({16'h1000, 8'h5A});
        @(negedge clk);
        bus.s_data = 8'h5B;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        bus.s_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rstn", cpu_rst_n, 0);
        chk("abort_sready", bus.s_ready, 0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= done;
        end
        chk("abort_nodone", seen, 0);
        chk("abort_sb", sb.size(), 0);
        cmd(16'h2000, 16'd1, h);
        pay = {8'h77};
        send(16'h2000, 1'b0);
        vec(16'h2000);
        wait_done(h, 8);

        // reset while in HOLD
        cmd(16'h3000, 16'd0, h);
        vec(16'h3000);
        repeat (4) @(negedge clk);
        chk("hold_busy", busy, 1);
        #2 rst = 1'b1;
        #1 rst_vals("rst_hold");
        bus.s_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_sready", bus.s_ready, 0);
        bus.s_valid = 1'b0;
        chk("rst_sb", sb.size(), 0);

        // reset during a reload from RUN, cutting a write off
        cmd(16'h6000, 16'd0, h);
        vec(16'h6000);
        wait_done(h, 7);
        cmd(16'h5000, 16'd4, h);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data = 8'hC1;
        sb.push_back({16'h5000, 8'hC1});
        @(negedge clk);
        bus.s_data = 8'hC2;
        @(posedge clk);
        #1;
        chk("cut_we", bus.mem_we, 1);
        rst = 1'b1;
        sb.delete();
        #1 rst_vals("rst_run");
        repeat (2) @(negedge clk);
        chk("rst_held_we", bus.mem_we, 0);
        rst = 1'b0;
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_vals("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
